cc_line_fill_unit: RTL and testbench

// Parametrised cache line-fill unit between the AXI R channel and the cache SRAM write port.

---
 rtl/cc_line_fill_unit.sv | 116 +++++++++++
 tb/tb_cc_line_fill_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_line_fill_unit.sv
// Cache line-fill unit: pops a miss address, gathers a wrap-ordered R burst into a line buffer,
// then issues one SRAM line write (or flags an error) and forwards the critical word early.
module cc_line_fill_unit #(
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 8,
  parameter int ADDR_W     = 32,
  parameter int INDEX_W    = 9,
  localparam int OFS_W     = $clog2(LINE_BEATS * DATA_W / 8),
  localparam int BEAT_W    = $clog2(LINE_BEATS),
  localparam int TAG_W     = ADDR_W - INDEX_W - OFS_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  input  logic [1:0]                   mem_rresp_i,
  input  logic                         mem_rlast_i,
  input  logic                         mem_rvalid_i,
  output logic                         mem_rready_o,
  input  logic                         miss_addr_fifo_empty_i,
  input  logic [ADDR_W-1:0]            miss_addr_fifo_rdata_i,
  output logic                         miss_addr_fifo_rden_o,
  output logic                         wren_o,
  output logic [INDEX_W-1:0]           waddr_o,
  output logic [TAG_W:0]               wdata_tag_o,
  output logic [LINE_BEATS*DATA_W-1:0] wdata_data_o,
  output logic                         crit_valid_o,
  output logic [DATA_W-1:0]            crit_data_o,
  output logic                         fill_err_o
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t              state_q, state_nxt;
  logic [BEAT_W-1:0]   cnt_q;
  logic [BEAT_W-1:0]   start_q;
  logic [BEAT_W-1:0]   slot;
  logic                err_q;
  logic                err_nxt;
  logic                pop;
  logic                beat_acc;
  logic                last_cnt;
  logic [DATA_W-1:0]   line_q [LINE_BEATS];
  logic                unused_addr_bits;

  // Sub-beat offset bits of the miss address carry no information for a line fill.
  assign unused_addr_bits = ^miss_addr_fifo_rdata_i[OFS_W-BEAT_W-1:0];

  assign beat_acc = mem_rvalid_i && mem_rready_o;
  assign last_cnt = (cnt_q == BEAT_W'(LINE_BEATS - 1));
  assign slot     = start_q + cnt_q;
  // A burst is malformed if rlast disagrees with the beat count in either direction.
  assign err_nxt  = err_q || (mem_rresp_i != 2'b00) || (last_cnt != mem_rlast_i);

  always_comb begin
    state_nxt             = state_q;
    pop                   = 1'b0;
    miss_addr_fifo_rden_o = 1'b0;
    mem_rready_o          = 1'b0;
    wren_o                = 1'b0;
    fill_err_o            = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst so nothing is popped while reset is held.
        pop                   = !miss_addr_fifo_empty_i && !rst;
        miss_addr_fifo_rden_o = pop;
        if (pop) state_nxt = FILL;
      end
      FILL: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i && (last_cnt || mem_rlast_i)) state_nxt = WRITE;
      end
      WRITE: begin
        wren_o     = !err_q;
        fill_err_o = err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_q      <= '0;
      err_q        <= 1'b0;
      waddr_o      <= '0;
      wdata_tag_o  <= '0;
      crit_valid_o <= 1'b0;
      crit_data_o  <= '0;
      for (int k = 0; k < LINE_BEATS; k++) line_q[k] <= '0;
    end else begin
      state_q      <= state_nxt;
      crit_valid_o <= beat_acc && (cnt_q == '0);
      if (beat_acc && (cnt_q == '0)) crit_data_o <= mem_rdata_i;
      if (pop) begin
        waddr_o     <= miss_addr_fifo_rdata_i[OFS_W +: INDEX_W];
        wdata_tag_o <= {1'b1, miss_addr_fifo_rdata_i[ADDR_W-1 -: TAG_W]};
        start_q     <= miss_addr_fifo_rdata_i[OFS_W-1 -: BEAT_W];
        cnt_q       <= '0;
        err_q       <= 1'b0;
      end
      if (beat_acc) begin
        line_q[slot] <= mem_rdata_i;
        cnt_q        <= cnt_q + 1'b1;
        err_q        <= err_nxt;
      end
    end
  end

  always_comb begin
    wdata_data_o = '0;
    for (int k = 0; k < LINE_BEATS; k++) wdata_data_o[k*DATA_W +: DATA_W] = line_q[k];
  end

endmodule

// File: tb/tb_cc_line_fill_unit.sv
// Directed bench for cc_line_fill_unit: aligned, wrapped, stalled, errored and reset-interrupted fills.
module tb_cc_line_fill_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  mem_rdata;
  logic [1:0]   mem_rresp;
  logic         mem_rlast;
  logic         mem_rvalid;
  logic         mem_rready;
  logic         fifo_empty;
  logic [31:0]  fifo_rdata;
  logic         fifo_rden;
  logic         wren;
  logic [8:0]   waddr;
  logic [17:0]  wdata_tag;
  logic [511:0] wdata_data;
  logic         crit_valid;
  logic [63:0]  crit_data;
  logic         fill_err;

  int vectors = 0;
  int miscompares = 0;

  cc_line_fill_unit dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_rdata_i            (mem_rdata),
    .mem_rresp_i            (mem_rresp),
    .mem_rlast_i            (mem_rlast),
    .mem_rvalid_i           (mem_rvalid),
    .mem_rready_o           (mem_rready),
    .miss_addr_fifo_empty_i (fifo_empty),
    .miss_addr_fifo_rdata_i (fifo_rdata),
    .miss_addr_fifo_rden_o  (fifo_rden),
    .wren_o                 (wren),
    .waddr_o                (waddr),
    .wdata_tag_o            (wdata_tag),
    .wdata_data_o           (wdata_data),
    .crit_valid_o           (crit_valid),
    .crit_data_o            (crit_data),
    .fill_err_o             (fill_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line: beat i of the burst lands in slot (start+i) mod 8.
  function automatic logic [511:0] mk_line(input logic [63:0] base, input int start);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[((start + i) % 8) * 64 +: 64] = base + 64'(i);
    return l;
  endfunction

  // Called at a negedge; leaves the bench at negedge+1 with the unit in FILL.
  task automatic pop_miss(input logic [31:0] a);
    fifo_empty = 1'b0;
    fifo_rdata = a;
    #1;
    chk("pop_rden_high", fifo_rden, 1);
    chk("pop_rready_idle", mem_rready, 0);
    @(negedge clk);
    fifo_empty = 1'b1;
    #1;
    chk("pop_rden_one_cycle", fifo_rden, 0);
    chk("fill_rready", mem_rready, 1);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [1:0] r, input logic l);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    mem_rresp  = r;
    mem_rlast  = l;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rresp  = 2'b00;
    mem_rlast  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wren"}, wren, 0);
    chk({tag, "_rden"}, fifo_rden, 0);
    chk({tag, "_rready"}, mem_rready, 0);
    chk({tag, "_crit_valid"}, crit_valid, 0);
    chk({tag, "_crit_data"}, crit_data, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_tag"}, wdata_tag, 0);
    chk({tag, "_data"}, wdata_data, 0);
    chk({tag, "_fill_err"}, fill_err, 0);
  endtask

  localparam logic [63:0] D = 64'hD0D0_1111_0000_0000;
  localparam logic [63:0] B = 64'hB0B0_2222_0000_0100;
  localparam logic [63:0] S = 64'h5555_3333_0000_0200;
  localparam logic [63:0] E = 64'hEEEE_4444_0000_0300;
  localparam logic [63:0] C = 64'hCCCC_5555_0000_0400;
  localparam logic [63:0] R = 64'h7777_6666_0000_0500;
  localparam logic [63:0] N = 64'h9999_8888_0000_0600;

  initial begin
    logic [511:0] line;
    rst        = 1'b1;
    mem_rdata  = '0;
    mem_rresp  = '0;
    mem_rlast  = 1'b0;
    mem_rvalid = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Aligned fill: start slot 0, critical word D0.
    pop_miss(32'h0000_1240);
    for (int i = 0; i < 8; i++) begin
      send_beat(D + 64'(i), 2'b00, i == 7);
      if (i == 0) begin
        chk("aligned_crit_valid", crit_valid, 1);
        chk("aligned_crit_data", crit_data, D);
      end
      if (i == 1) chk("aligned_crit_pulse", crit_valid, 0);
      if (i < 7) chk("aligned_no_early_wren", wren, 0);
    end
    chk("aligned_wren", wren, 1);
    chk("aligned_waddr", waddr, 9'h049);
    chk("aligned_tag", wdata_tag, 18'h20000);
    line = {D + 64'd7, D + 64'd6, D + 64'd5, D + 64'd4, D + 64'd3, D + 64'd2, D + 64'd1, D};
    chk("aligned_line", wdata_data, line);
    chk("aligned_write_rready", mem_rready, 0);
    chk("aligned_fill_err", fill_err, 0);
    @(negedge clk);
    chk("aligned_wren_one_cycle", wren, 0);
    chk("aligned_waddr_hold", waddr, 9'h049);
    chk("aligned_line_hold", wdata_data, line);

    // Wrap fill: start slot 7.
    pop_miss(32'hABCD_E078);
    for (int i = 0; i < 8; i++) begin
      send_beat(B + 64'(i), 2'b00, i == 7);
      if (i == 0) chk("wrap_crit_data", crit_data, B);
    end
    chk("wrap_wren", wren, 1);
    chk("wrap_waddr", waddr, 9'h181);
    chk("wrap_tag", wdata_tag, 18'h3579B);
    chk("wrap_slot7", wdata_data[7*64 +: 64], B);
    chk("wrap_slot0", wdata_data[0 +: 64], B + 64'd1);
    chk("wrap_slot6", wdata_data[6*64 +: 64], B + 64'd7);
    chk("wrap_line", wdata_data, mk_line(B, 7));
    @(negedge clk);
    chk("wrap_wren_one_cycle", wren, 0);

    // Stalled beats: 3 idle cycles after beat 3; a waiting miss must not be popped mid-fill.
    pop_miss(32'h0000_0FE8);
    for (int i = 0; i < 3; i++) send_beat(S + 64'(i), 2'b00, 1'b0);
    fifo_empty = 1'b0;
    fifo_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_rready", mem_rready, 1);
      chk("stall_no_rden", fifo_rden, 0);
      chk("stall_no_wren", wren, 0);
      @(negedge clk);
    end
    fifo_empty = 1'b1;
    for (int i = 3; i < 8; i++) send_beat(S + 64'(i), 2'b00, i == 7);
    chk("stall_wren", wren, 1);
    chk("stall_waddr", waddr, 9'h03F);
    chk("stall_tag", wdata_tag, 18'h20000);
    chk("stall_line", wdata_data, mk_line(S, 5));
    @(negedge clk);
    chk("stall_wren_one_cycle", wren, 0);

    // Bad RRESP on beat 5 aborts the fill.
    pop_miss(32'h0000_2000);
    for (int i = 0; i < 8; i++) send_beat(E + 64'(i), (i == 5) ? 2'b10 : 2'b00, i == 7);
    chk("rresp_no_wren", wren, 0);
    chk("rresp_fill_err", fill_err, 1);
    @(negedge clk);
    chk("rresp_fill_err_one_cycle", fill_err, 0);
    chk("rresp_wren_after", wren, 0);

    // Next miss after an error fills cleanly.
    pop_miss(32'h0000_2040);
    for (int i = 0; i < 8; i++) send_beat(C + 64'(i), 2'b00, i == 7);
    chk("recover_wren", wren, 1);
    chk("recover_fill_err", fill_err, 0);
    chk("recover_waddr", waddr, 9'h081);
    chk("recover_line", wdata_data, mk_line(C, 0));
    @(negedge clk);

    // Early RLAST on beat 4.
    pop_miss(32'h0000_3000);
    for (int i = 0; i < 4; i++) send_beat(R + 64'(i), 2'b00, i == 3);
    chk("rlast_no_wren", wren, 0);
    chk("rlast_fill_err", fill_err, 1);
    chk("rlast_rready", mem_rready, 0);
    @(negedge clk);
    chk("rlast_fill_err_one_cycle", fill_err, 0);
    chk("rlast_idle_rready", mem_rready, 0);

    // Async reset after beat 3, then a fresh miss.
    pop_miss(32'h0000_4000);
    for (int i = 0; i < 3; i++) send_beat(R + 64'(i), 2'b00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    chk("midrst_no_wren", wren, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_no_wren", wren, 0);
    chk("postrst_no_rden", fifo_rden, 0);
    pop_miss(32'h0001_8090);
    for (int i = 0; i < 8; i++) begin
      send_beat(N + 64'(i), 2'b00, i == 7);
      if (i == 0) chk("postrst_crit_data", crit_data, N);
    end
    chk("postrst_wren", wren, 1);
    chk("postrst_waddr", waddr, 9'h002);
    chk("postrst_tag", wdata_tag, 18'h20003);
    chk("postrst_line", wdata_data, mk_line(N, 2));
    @(negedge clk);
    chk("postrst_wren_one_cycle", wren, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
